// File: rtl/sample_capture.sv
// Decimating, edge-triggered capture of 256 ADC samples into a private buffer,
// published to the display-facing array in one step on the vertical-blank rising edge.
module sample_capture #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic [11:0] trig_level,
  input  logic        trig_falling,
  input  logic        auto_en,
  input  logic [3:0]  decim,
  input  logic        vblnk,
  output logic [11:0] data_display [0:DEPTH-1],
  output logic        frame_done,
  output logic        forced,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t             r_state;
  logic [11:0]        r_cap  [0:DEPTH-1];
  logic [11:0]        r_disp [0:DEPTH-1];
  logic [IDX_W-1:0]   r_wr_idx;
  logic [3:0]         r_dec_cnt;
  logic [11:0]        r_prev;
  logic               r_prev_ok;
  logic [15:0]        r_timeout_cnt;
  logic               r_vblnk_d;
  logic               r_forced_int;
  logic               r_forced;
  logic               r_frame_done;

  logic               w_taken;
  logic               w_trig_edge;
  logic               w_timeout;
  logic               w_start;
  logic               w_cap_we;
  logic [IDX_W-1:0]   w_cap_idx;
  logic               w_publish;

  // adc_valid qualifies adc_data for exactly the cycle it is high; there is no backpressure.
  // The decimator is frozen in HOLD so no sample is consumed while waiting to publish.
  assign w_taken     = adc_valid && (r_dec_cnt == 4'd0) && (r_state != ST_HOLD);
  assign w_trig_edge = r_prev_ok && (trig_falling ? ((r_prev > trig_level) && (adc_data <= trig_level))
                                                  : ((r_prev < trig_level) && (adc_data >= trig_level)));
  assign w_timeout   = auto_en && (r_timeout_cnt == TO_LAST);
  assign w_start     = w_taken && (r_state == ST_ARMED) && (w_trig_edge || w_timeout);
  assign w_cap_we    = w_start || (w_taken && (r_state == ST_CAPTURE));
  assign w_cap_idx   = (r_state == ST_ARMED) ? '0 : r_wr_idx;
  assign w_publish   = (r_state == ST_HOLD) && vblnk && !r_vblnk_d;

  assign data_display = r_disp;
  assign frame_done   = r_frame_done;
  assign forced       = r_forced;
  assign busy         = (r_state != ST_ARMED);
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cap[i]  <= '0;
        r_disp[i] <= '0;
      end
    end else begin
      if (w_cap_we) r_cap[w_cap_idx] <= adc_data;
      if (w_publish) begin
        for (int i = 0; i < DEPTH; i++) r_disp[i] <= r_cap[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_ARMED;
      r_wr_idx      <= '0;
      r_dec_cnt     <= 4'd0;
      r_prev        <= 12'd0;
      r_prev_ok     <= 1'b0;
      r_timeout_cnt <= 16'd0;
      r_vblnk_d     <= 1'b0;
      r_forced_int  <= 1'b0;
      r_forced      <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_vblnk_d    <= vblnk;
      r_frame_done <= w_publish;

      if (adc_valid && (r_state != ST_HOLD)) begin
        r_dec_cnt <= (r_dec_cnt == 4'd0) ? decim : (r_dec_cnt - 4'd1);
      end

      case (r_state)
        ST_ARMED: begin
          if (w_taken) begin
            r_prev    <= adc_data;
            r_prev_ok <= 1'b1;
            if (w_start) begin
              r_wr_idx     <= IDX_W'(1);
              r_forced_int <= !w_trig_edge;
              r_state      <= ST_CAPTURE;
            end else if (r_timeout_cnt != TO_LAST) begin
              // Saturates one short of the timeout so enabling auto later fires promptly.
              r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
          end
        end
        ST_CAPTURE: begin
          if (w_taken) begin
            r_wr_idx <= r_wr_idx + IDX_W'(1);
            if (r_wr_idx == IDX_W'(DEPTH - 1)) r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_publish) begin
            r_forced      <= r_forced_int;
            r_prev_ok     <= 1'b0;
            r_timeout_cnt <= 16'd0;
            r_state       <= ST_ARMED;
          end
        end
        default: r_state <= ST_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture: trigger polarity, decimation, auto-trigger,
// vblnk gating and asynchronous reset, with hand-computed frame contents.
module tb_sample_capture;

  logic        clk;
  logic        rst;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [11:0] trig_level;
  logic        trig_falling;
  logic        auto_en;
  logic [3:0]  decim;
  logic        vblnk;
  logic [11:0] data_display [0:255];
  logic        frame_done;
  logic        forced;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  int fd_count = 0;
  int fd0;

  sample_capture #(.DEPTH(256), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .auto_en      (auto_en),
    .decim        (decim),
    .vblnk        (vblnk),
    .data_display (data_display),
    .frame_done   (frame_done),
    .forced       (forced),
    .busy         (busy),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks: all called right after a falling edge
  task automatic send(input logic [11:0] v);
    adc_data  = v;
    adc_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    adc_valid = 1'b0;
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic pulse_vblnk(input string tag);
    adc_valid = 1'b0;
    vblnk = 1'b1;
    @(negedge clk);
    check({tag, "_fd_hi"}, {31'd0, frame_done}, 32'd1);
    @(negedge clk);
    check({tag, "_fd_lo"}, {31'd0, frame_done}, 32'd0);
    vblnk = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [11:0] v);
    int diffs;
    diffs = 0;
    for (int k = 0; k < 256; k++) if (data_display[k] !== v) diffs++;
    check(tag, diffs, 32'd0);
  endtask

  task automatic async_reset();
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] v;
    rst = 1'b0; adc_data = '0; adc_valid = 1'b0; trig_level = 12'd2048;
    trig_falling = 1'b0; auto_en = 1'b0; decim = 4'd0; vblnk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // reset state
    check_all("rst_disp_zero", 12'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_forced", {31'd0, forced}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // 1: rising trigger on a ramp of step 8
    for (int i = 0; i < 512; i++) send(12'(i * 8));
    idle(2);
    check("t1_busy_hold", {31'd0, busy}, 32'd1);
    check("t1_state_hold", {30'd0, dbg_state}, 32'd2);
    check("t1_no_early_pub", fd_count, 32'd0);
    pulse_vblnk("t1");
    check("t1_d0", data_display[0], 32'd2048);
    check("t1_d1", data_display[1], 32'd2056);
    check("t1_d255", data_display[255], 32'd4088);
    check("t1_forced", {31'd0, forced}, 32'd0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // 2: falling trigger, ramp down by 8 with 12-bit wrap
    trig_falling = 1'b1; trig_level = 12'd1000;
    v = 12'd4088;
    for (int i = 0; i < 642; i++) begin
      send(v);
      v = v - 12'd8;
    end
    idle(2);
    check("t2_busy_hold", {31'd0, busy}, 32'd1);
    pulse_vblnk("t2");
    check("t2_d0", data_display[0], 32'd1000);
    check("t2_d1", data_display[1], 32'd992);
    check("t2_d255", data_display[255], 32'd3056);
    check("t2_forced", {31'd0, forced}, 32'd0);

    // 3: decimation keeps every 4th sample
    trig_falling = 1'b0; trig_level = 12'd100; decim = 4'd3;
    for (int i = 0; i < 1124; i++) send(12'(i));
    idle(2);
    pulse_vblnk("t3");
    check("t3_d0", data_display[0], 32'd100);
    check("t3_d1", data_display[1], 32'd104);
    check("t3_d255", data_display[255], 32'd1120);
    decim = 4'd0;

    // 4a: no auto-trigger, constant input never crosses the level
    @(negedge clk);
    async_reset();
    trig_level = 12'd2048; auto_en = 1'b0;
    fd0 = fd_count;
    for (int i = 0; i < 10000; i++) send(12'd100);
    idle(2);
    check("t4a_no_frame", fd_count - fd0, 32'd0);
    check("t4a_busy", {31'd0, busy}, 32'd0);
    check_all("t4a_disp_zero", 12'd0);

    // 4b: auto-trigger on the 16th taken sample
    async_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 15; i++) send(12'd100);
    check("t4b_not_yet", {31'd0, busy}, 32'd0);
    send(12'd100);
    check("t4b_triggered", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 265; i++) send(12'd100);
    idle(1);
    check("t4b_state_hold", {30'd0, dbg_state}, 32'd2);
    pulse_vblnk("t4b");
    check_all("t4b_all_100", 12'd100);
    check("t4b_forced", {31'd0, forced}, 32'd1);
    auto_en = 1'b0;

    // 5: vblnk during CAPTURE is ignored; vblnk already high at HOLD entry waits for a new edge
    fd0 = fd_count;
    for (int i = 0; i < 512; i++) begin
      if (i == 356) vblnk = 1'b1;
      if (i == 358) vblnk = 1'b0;
      if (i == 506) vblnk = 1'b1;
      send(12'(i * 8));
    end
    idle(5);
    check("t5_no_pub", fd_count - fd0, 32'd0);
    check("t5_busy_hold", {31'd0, busy}, 32'd1);
    check("t5_disp_old", data_display[0], 32'd100);
    vblnk = 1'b0;
    @(negedge clk);
    pulse_vblnk("t5");
    check("t5_d0", data_display[0], 32'd2048);
    check("t5_d100", data_display[100], 32'd2848);
    check("t5_d255", data_display[255], 32'd4088);
    check("t5_forced", {31'd0, forced}, 32'd0);

    // 6: asynchronous reset mid-capture
    fd0 = fd_count;
    for (int i = 0; i < 300; i++) send(12'(i * 8));
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check_all("t6_disp_cleared", 12'd0);
    check("t6_busy_cleared", {31'd0, busy}, 32'd0);
    check("t6_forced_cleared", {31'd0, forced}, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    idle(3);
    check("t6_no_frame", fd_count - fd0, 32'd0);
    for (int i = 0; i < 512; i++) send(12'(i * 8));
    idle(2);
    pulse_vblnk("t6");
    check("t6_d0", data_display[0], 32'd2048);
    check("t6_d1", data_display[1], 32'd2056);
    check("t6_d255", data_display[255], 32'd4088);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
